// File: rtl/game_flow_ctrl.sv
// Game flow sequencer: tick divider, IDLE/RESPAWN/PLAY/DYING/WIN/GAMEOVER FSM, lives and landing score.
// Define GAME_PAUSE_EN to enable the pause button and the PAUSED state.
module game_flow_ctrl #(
   parameter int unsigned TICK_DIV    = 1,
   parameter int unsigned LIVES       = 3,
   parameter int unsigned DEATH_TICKS = 60,
   parameter logic [9:0]  FALL_Y      = 10'd470
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        frame_start,
   input  logic        start_btn,
   input  logic        pause_btn,
   input  logic        player_hit,
   input  logic        reached_goal,
   input  logic [9:0]  player_y,
   input  logic        jump_landed_pulse,
   output logic        game_tick,
   output logic        freeze,
   output logic        respawn_n,
   output logic [2:0]  lives,
   output logic [15:0] score,
   output logic [2:0]  state
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_RESPAWN  = 3'd1,
      S_PLAY     = 3'd2,
      S_DYING    = 3'd3,
      S_WIN      = 3'd4,
      S_GAMEOVER = 3'd5,
      S_PAUSED   = 3'd6
   } state_t;

`ifdef GAME_PAUSE_EN
   localparam bit PAUSE_EN = 1'b1;
`else
   localparam bit PAUSE_EN = 1'b0;
`endif

   localparam logic [3:0] DIV_LAST   = 4'(TICK_DIV - 1);
   localparam logic [7:0] DEATH_LAST = 8'(DEATH_TICKS - 1);
   localparam logic [2:0] LIVES_INIT = 3'(LIVES);

   state_t      state_reg, state_next;
   logic [3:0]  div_cnt_reg;
   logic [7:0]  dying_cnt_reg, dying_cnt_next;
   logic [2:0]  lives_reg, lives_next;
   logic [15:0] score_reg, score_next;
   logic        start_prev_reg, pause_prev_reg;
   logic        game_tick_reg, freeze_reg, respawn_n_reg;
   logic        start_rise, pause_rise, death;

   assign start_rise = start_btn & ~start_prev_reg;
   assign pause_rise = pause_btn & ~pause_prev_reg;
   assign death      = player_hit | (player_y >= FALL_Y);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg      <= S_IDLE;
         div_cnt_reg    <= '0;
         dying_cnt_reg  <= '0;
         lives_reg      <= LIVES_INIT;
         score_reg      <= '0;
         start_prev_reg <= 1'b0;
         pause_prev_reg <= 1'b0;
         game_tick_reg  <= 1'b0;
         freeze_reg     <= 1'b1;
         respawn_n_reg  <= 1'b1;
      end else begin
         start_prev_reg <= start_btn;
         pause_prev_reg <= pause_btn;
         game_tick_reg  <= 1'b0;
         if (frame_start) begin
            if (div_cnt_reg == DIV_LAST) begin
               div_cnt_reg   <= '0;
               game_tick_reg <= 1'b1;
            end else begin
               div_cnt_reg <= div_cnt_reg + 4'd1;
            end
         end
         state_reg     <= state_next;
         dying_cnt_reg <= dying_cnt_next;
         lives_reg     <= lives_next;
         score_reg     <= score_next;
         // Registered from the next state so freeze/respawn line up with the state they describe.
         freeze_reg    <= (state_next != S_PLAY);
         respawn_n_reg <= (state_next != S_RESPAWN);
      end
   end

   always_comb begin
      state_next     = state_reg;
      dying_cnt_next = dying_cnt_reg;
      lives_next     = lives_reg;
      score_next     = score_reg;
      case (state_reg)
         S_IDLE: begin
            if (start_rise) begin
               lives_next = LIVES_INIT;
               score_next = '0;
               state_next = S_RESPAWN;
            end
         end
         S_RESPAWN: state_next = S_PLAY;
         S_PLAY: begin
            if (jump_landed_pulse && (score_reg != 16'hFFFF))
               score_next = score_reg + 16'd1;
            // Death outranks goal; both are only sampled on a game tick.
            if (game_tick_reg && death) begin
               state_next     = S_DYING;
               dying_cnt_next = '0;
               if (lives_reg != 3'd0)
                  lives_next = lives_reg - 3'd1;
            end else if (game_tick_reg && reached_goal) begin
               state_next = S_WIN;
            end else if (PAUSE_EN && pause_rise) begin
               state_next = S_PAUSED;
            end
         end
         S_DYING: begin
            if (game_tick_reg) begin
               dying_cnt_next = dying_cnt_reg + 8'd1;
               if (dying_cnt_reg == DEATH_LAST)
                  state_next = (lives_reg == 3'd0) ? S_GAMEOVER : S_RESPAWN;
            end
         end
         S_WIN, S_GAMEOVER: begin
            if (start_rise)
               state_next = S_IDLE;
         end
         S_PAUSED: begin
            if (PAUSE_EN && pause_rise)
               state_next = S_PLAY;
         end
         default: state_next = S_IDLE;
      endcase
   end

   assign game_tick = game_tick_reg;
   assign freeze    = freeze_reg;
   assign respawn_n = respawn_n_reg;
   assign lives     = lives_reg;
   assign score     = score_reg;
   assign state     = state_reg;

endmodule
